// File: rtl/ram_rd_ctrl.sv
// Sequential read controller for block-RAM port B: sweeps len words from base_addr into a 2-entry stream buffer.
// Optional running checksum of sent words is built when RAM_RD_CHKSUM_EN is defined.
module ram_rd_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_doutb,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   accepted_q, accepted_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        fill_q, fill_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic              pop_s;
  logic              room_s;
  logic              issue_s;

  // Space check counts the word still in the RAM pipeline so the buffer can never overflow.
  always_comb begin
    pop_s   = (fill_q != 2'd0) && m_ready;
    room_s  = (({1'b0, fill_q} + {2'b00, inflight_q}) - {2'b00, pop_s}) < 3'd2;
    issue_s = (state_q == S_READ) && (issued_q != len_q) && room_s;
  end

  // Next-state, counters and buffer update.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    accepted_d = accepted_q + {{ADDR_W{1'b0}}, pop_s};
    inflight_d = issue_s;
    fill_d     = fill_q + {1'b0, inflight_q} - {1'b0, pop_s};
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          len_d      = len;
          issued_d   = '0;
          accepted_d = '0;
          state_d    = (len == '0) ? S_DONE : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (issue_s) begin
          issued_d = issued_q + {{ADDR_W{1'b0}}, 1'b1};
          if (issued_d == len_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if (accepted_d == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (inflight_q) begin
      if (wr_ptr_q) begin
        buf1_d = ram_doutb;
      end else begin
        buf0_d = ram_doutb;
      end
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State and datapath registers; reset also drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      fill_q     <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      inflight_q <= inflight_d;
      fill_q     <= fill_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  assign ram_enb   = issue_s;
  assign ram_addrb = issue_s ? (base_q + issued_q[ADDR_W-1:0]) : '0;
  assign m_valid   = (fill_q != 2'd0);
  assign m_data    = rd_ptr_q ? buf1_q : buf0_q;
  assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

`ifdef RAM_RD_CHKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;

  // Checksum clears on an accepted start and otherwise adds every transferred word.
  always_comb begin
    chk_d = chk_q;
    if ((state_q == S_IDLE) && start) begin
      chk_d = '0;
    end else if (pop_s) begin
      chk_d = chk_q + m_data;
    end else begin
      chk_d = chk_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign checksum = chk_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_rd_ctrl.sv
// Self-checking bench for ram_rd_ctrl: behavioural RAM with mem[i]=i, scoreboard of expected stream words.
module tb_ram_rd_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [16:0] len;
  logic        busy;
  logic        done;
  logic        ram_enb;
  logic [15:0] ram_addrb;
  logic [15:0] ram_doutb;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] checksum;

  logic [15:0] mem [65536];
  logic [15:0] sb [$];
  int          n_tests;
  int          n_fail;
  int          xfers;
  int          iss_cnt;
  int          xfer_cnt;
  logic [15:0] exp_addr;
  logic [15:0] chk_exp;
  logic        enb_seen;
  logic        valid_seen;
  logic        hold_v;
  logic [15:0] hold_d;
  int          mode;
  int          ph;

  ram_rd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .checksum  (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i);
  end

  // RAM port B: one-cycle registered read
  always @(posedge clk) begin
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] chk_model();
`ifdef RAM_RD_CHKSUM_EN
    return chk_exp;
`else
    return 16'h0000;
`endif
  endfunction

  // ready pattern: mode 0 always ready, mode 1 one cycle on then two off
  initial begin
    m_ready = 1'b1;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) begin
        m_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // monitor: address sequence, occupancy bound, stall stability, scoreboard
  always @(negedge clk) begin
    if (rst) begin
      iss_cnt  = 0;
      xfer_cnt = 0;
      hold_v   = 1'b0;
    end else begin
      if (mode == 1) check("occupancy", ((iss_cnt - xfer_cnt) <= 2) ? 1 : 0, 1);
      if (ram_enb) begin
        check("addr", ram_addrb, exp_addr);
        exp_addr = exp_addr + 16'd1;
        enb_seen = 1'b1;
        iss_cnt++;
      end
      if (m_valid) valid_seen = 1'b1;
      if (hold_v && m_valid) check("stall_stable", m_data, hold_d);
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          check("data", m_data, sb.pop_front());
        end
        xfers++;
        xfer_cnt++;
      end
    end
  end

  task automatic start_xfer(input logic [15:0] b, input logic [16:0] l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    len       = l;
    exp_addr  = b;
    xfers     = 0;
    enb_seen  = 1'b0;
    valid_seen = 1'b0;
    chk_exp   = 16'h0000;
    for (int i = 0; i < int'(l); i++) begin
      logic [15:0] v;
      v = b + 16'(i);
      sb.push_back(v);
      chk_exp = chk_exp + v;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat);
    int cyc;
    cyc = 1;
    while (!done && cyc < 70000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
    end else begin
      if (exp_lat >= 0) check("done_lat", cyc, exp_lat);
      check("busy_at_done", busy, 0);
      check("checksum", checksum, chk_model());
      check("sb_drained", sb.size(), 0);
      @(posedge clk);
      #1;
      check("done_pulse", done, 0);
      check("chk_hold", checksum, chk_model());
    end
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_enb", ram_enb, 0);
    check("rst_addr", ram_addrb, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_chk", checksum, 0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    mode      = 0;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = 16'h0000;
    len       = 17'd0;
    exp_addr  = 16'h0000;
    chk_exp   = 16'h0000;
    xfers     = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;

    // full address space sweep
    start_xfer(16'h0000, 17'h10000);
    wait_done(65539);
    check("full_count", xfers, 65536);

    // address wrap
    start_xfer(16'hFFFE, 17'd4);
    check("busy_t1", busy, 1);
    check("enb_t1", ram_enb, 1);
    wait_done(7);
    check("wrap_count", xfers, 4);

    // backpressure
    mode = 1;
    start_xfer(16'h0200, 17'd8);
    wait_done(-1);
    check("stall_count", xfers, 8);
    mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // zero length
    start_xfer(16'h1234, 17'd0);
    wait_done(1);
    check("len0_enb", enb_seen, 0);
    check("len0_valid", valid_seen, 0);

    // reset mid-transfer, then a fresh short transfer
    start_xfer(16'h0100, 17'd10);
    begin
      int g;
      g = 0;
      while (xfers < 3 && g < 100) begin
        @(posedge clk);
        #1;
        g++;
      end
      check("rst_wait", (xfers >= 3) ? 1 : 0, 1);
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
    start_xfer(16'h0300, 17'd2);
    wait_done(5);
    check("post_rst_count", xfers, 2);

    // start while busy is ignored
    start_xfer(16'h0040, 17'd6);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 16'h0999;
    len       = 17'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_mid", busy, 1);
    wait_done(7);
    check("restart_count", xfers, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
